sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/rr_arb2.sv | 35 +++
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizes for the dual-port SRAM arbiter.
// Holds the controller state enum and the macro geometry.
package sram_arbiter_pkg;

    localparam int SRAM_DEPTH = 512;
    localparam int SRAM_AW    = 9;
    localparam int SRAM_DW    = 8;
    localparam int ADDR_W     = 10;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
// Ports: clk, rst_n (sync, active-low), en, valid[1:0] in; gnt[1:0] out.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] gnt
);

    logic ptr;

    // The pointer names the preferred port; the other port wins
    // only when the preferred one is idle.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (valid[ptr]) begin
                gnt[ptr] = 1'b1;
            end else if (valid[~ptr]) begin
                gnt[~ptr] = 1'b1;
            end
        end
    end

    // After a grant to port i, prefer the other port next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto two 512x8 SRAM macros, zero-fills after reset.
// Ports: req_* (valid/ready/we/addr/wdata/wmask), rsp_valid/rsp_rdata, init_done, sram_* macro pins.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter bit INIT_EN    = 1'b1,
    parameter int NUM_MACROS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0]                           req_we,
    input  logic [1:0][ADDR_W-1:0]               req_addr,
    input  logic [1:0][SRAM_DW-1:0]              req_wdata,
    input  logic [1:0][SRAM_DW-1:0]              req_wmask,
    output logic [1:0]                           rsp_valid,
    output logic [SRAM_DW-1:0]                   rsp_rdata,
    output logic                                 init_done,
    output logic [NUM_MACROS-1:0]                sram_cen_n,
    output logic                                 sram_gwen_n,
    output logic [SRAM_DW-1:0]                   sram_wen_n,
    output logic [SRAM_AW-1:0]                   sram_a,
    output logic [SRAM_DW-1:0]                   sram_d,
    input  logic [NUM_MACROS-1:0][SRAM_DW-1:0]   sram_q
);

    localparam logic [SRAM_AW-1:0] LAST_A = SRAM_AW'(SRAM_DEPTH - 1);

    state_e               state;
    logic [SRAM_AW-1:0]   init_cnt;
    logic                 run_en;
    logic                 init_on;
    logic [1:0]           gnt;
    logic                 gsel;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_we;
    logic [SRAM_DW-1:0]   sel_wdata;
    logic [SRAM_DW-1:0]   sel_wmask;
    logic [1:0]           rsp_pend;
    logic                 rsp_bank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_RESET: state <= INIT_EN ? ST_INIT : ST_RUN;
                ST_INIT: begin
                    if (init_cnt == LAST_A) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_RESET;
            endcase
        end
    end

    // Reset is folded in combinationally so an asserted rst_n
    // silences the macros and handshakes in the same cycle.
    assign run_en    = rst_n && (state == ST_RUN);
    assign init_on   = rst_n && (state == ST_INIT);
    assign init_done = run_en;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .valid (req_valid),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign gsel      = gnt[1];
    assign sel_addr  = req_addr[gsel];
    assign sel_we    = req_we[gsel];
    assign sel_wdata = req_wdata[gsel];
    assign sel_wmask = req_wmask[gsel];

    always_comb begin
        sram_cen_n  = '1;
        sram_gwen_n = 1'b0;
        sram_wen_n  = '0;
        sram_a      = '0;
        sram_d      = '0;
        if (init_on) begin
            sram_cen_n = '0;
            sram_a     = init_cnt;
        end else if (|gnt) begin
            sram_cen_n[sel_addr[ADDR_W-1]] = 1'b0;
            sram_gwen_n = ~sel_we;
            sram_wen_n  = sel_we ? ~sel_wmask : '1;
            sram_a      = sel_addr[SRAM_AW-1:0];
            sram_d      = sel_wdata;
        end
    end

    // Read responses: remember which port and macro, return next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_pend <= 2'b00;
            rsp_bank <= 1'b0;
        end else begin
            rsp_pend <= sel_we ? 2'b00 : gnt;
            if (|gnt) begin
                rsp_bank <= sel_addr[ADDR_W-1];
            end
        end
    end

    assign rsp_valid = rst_n ? rsp_pend : 2'b00;
    assign rsp_rdata = (|rsp_valid) ? sram_q[rsp_bank] : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural two-macro SRAM model.
// Table-driven RUN vectors plus init, round-robin, mask and reset-abort sequences.
module tb_sram_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][9:0]  req_addr;
    logic [1:0][7:0]  req_wdata;
    logic [1:0][7:0]  req_wmask;
    logic [1:0]       rsp_valid;
    logic [7:0]       rsp_rdata;
    logic             init_done;
    logic [1:0]       sram_cen_n;
    logic             sram_gwen_n;
    logic [7:0]       sram_wen_n;
    logic [8:0]       sram_a;
    logic [7:0]       sram_d;
    logic [1:0][7:0]  sram_q;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.INIT_EN(1'b1), .NUM_MACROS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .sram_cen_n  (sram_cen_n),
        .sram_gwen_n (sram_gwen_n),
        .sram_wen_n  (sram_wen_n),
        .sram_a      (sram_a),
        .sram_d      (sram_d),
        .sram_q      (sram_q)
    );

    // Macro model: bit-masked write, read data one cycle after the edge.
    // Contents are scrambled while reset is low so the zero-fill is visible.
    logic [7:0] mem [2][512];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 512; i++)
                    mem[m][i] <= 8'h5A;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (!sram_cen_n[m]) begin
                    if (!sram_gwen_n)
                        mem[m][sram_a] <= (mem[m][sram_a] & sram_wen_n) | (sram_d & ~sram_wen_n);
                    sram_q[m] <= mem[m][sram_a];
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nonzero_words();
        int n = 0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 512; i++)
                if (mem[m][i] !== 8'h00) n++;
        return n;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] m0, input logic [7:0] m1);
        req_valid    = v;
        req_we       = we;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        req_wmask[0] = m0;
        req_wmask[1] = m1;
    endtask

    // Counts edges after reset release until init_done, optionally
    // stopping early once INIT drives address stop_at.
    task automatic run_init(input int stop_at, output int edges, output logic seen_rsp);
        edges = 600;
        seen_rsp = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            @(negedge clk);
            seen_rsp = seen_rsp | (|rsp_valid);
            if (init_done) begin
                edges = k;
                break;
            end
            if (stop_at >= 0 && sram_cen_n == 2'b00 && int'(sram_a) == stop_at) begin
                edges = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [9:0] a0;
        logic [9:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [1:0] e_ready;
        logic [1:0] e_cen;
        logic       e_gwen;
        logic [7:0] e_wen;
        logic [8:0] e_a;
        logic [7:0] e_d;
        logic [1:0] e_rv;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs [9];
    int   edges;
    logic seen;

    initial begin
        vecs[0] = '{2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b11, 1'b0, 8'h00, 9'h000, 8'h00, 2'b00, 8'h00};
        vecs[1] = '{2'b01, 2'b01, 10'h005, 10'h000, 8'hA5, 8'h00, 8'hFF, 8'h00, 2'b01, 2'b10, 1'b0, 8'h00, 9'h005, 8'hA5, 2'b00, 8'h00};
        vecs[2] = '{2'b01, 2'b00, 10'h005, 10'h000, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'b10, 1'b1, 8'hFF, 9'h005, 8'h00, 2'b00, 8'h00};
        vecs[3] = '{2'b11, 2'b00, 10'h005, 10'h205, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 2'b01, 1'b1, 8'hFF, 9'h005, 8'h00, 2'b01, 8'hA5};
        vecs[4] = '{2'b11, 2'b00, 10'h005, 10'h205, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'b10, 1'b1, 8'hFF, 9'h005, 8'h00, 2'b10, 8'h00};
        vecs[5] = '{2'b11, 2'b10, 10'h005, 10'h3FF, 8'h00, 8'h3C, 8'h00, 8'hF0, 2'b10, 2'b01, 1'b0, 8'h0F, 9'h1FF, 8'h3C, 2'b01, 8'hA5};
        vecs[6] = '{2'b10, 2'b00, 10'h005, 10'h3FF, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 2'b01, 1'b1, 8'hFF, 9'h1FF, 8'h00, 2'b00, 8'h00};
        vecs[7] = '{2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b11, 1'b0, 8'h00, 9'h000, 8'h00, 2'b10, 8'h30};
        vecs[8] = '{2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b11, 1'b0, 8'h00, 9'h000, 8'h00, 2'b00, 8'h00};

        // Reset with both ports requesting reads.
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 10'h005, 10'h205, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_cen", 32'(sram_cen_n), 32'h3);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);

        // Release and walk through INIT.
        rst_n = 1'b1;
        edges = 0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                check("init_a_first", 32'(sram_a), 32'h0);
                check("init_cen", 32'(sram_cen_n), 32'h0);
                check("init_we", 32'({sram_gwen_n, sram_wen_n, sram_d}), 32'h0);
                check("init_ready", 32'(req_ready), 32'h0);
                req_valid = 2'b00;
            end
            if (k == 512) check("init_a_last", 32'(sram_a), 32'd511);
            if (init_done) begin
                edges = k;
                break;
            end
        end
        check("init_edges", 32'(edges), 32'd513);
        check("zero_fill", 32'(nonzero_words()), 32'h0);

        // Table of single-cycle RUN vectors, pointer starts at 0.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1,
                  vecs[i].d0, vecs[i].d1, vecs[i].m0, vecs[i].m1);
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_cen", i), 32'(sram_cen_n), 32'(vecs[i].e_cen));
            check($sformatf("v%0d_gwen", i), 32'(sram_gwen_n), 32'(vecs[i].e_gwen));
            check($sformatf("v%0d_wen", i), 32'(sram_wen_n), 32'(vecs[i].e_wen));
            check($sformatf("v%0d_a", i), 32'(sram_a), 32'(vecs[i].e_a));
            check($sformatf("v%0d_d", i), 32'(sram_d), 32'(vecs[i].e_d));
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            check($sformatf("v%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rd));
            @(negedge clk);
        end

        // Continuous reads on both ports: grants alternate 0,1,0,1.
        drive(2'b11, 2'b00, 10'h005, 10'h3FF, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) req_valid = 2'b00;
            #1;
            if (c < 4) check($sformatf("rr%0d_ready", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            if (c > 0) begin
                check($sformatf("rr%0d_rsp_valid", c), 32'(rsp_valid), (c % 2 == 1) ? 32'h1 : 32'h2);
                check($sformatf("rr%0d_rsp_rdata", c), 32'(rsp_rdata), (c % 2 == 1) ? 32'hA5 : 32'h30);
            end
            @(negedge clk);
        end

        // Full write, masked write, read back on macro 1.
        drive(2'b01, 2'b01, 10'h205, 10'h000, 8'hFF, 8'h00, 8'hFF, 8'h00);
        #1 check("mask_w1_cen", 32'(sram_cen_n), 32'h1);
        @(negedge clk);
        drive(2'b01, 2'b01, 10'h205, 10'h000, 8'h00, 8'h00, 8'h0F, 8'h00);
        #1 check("mask_w2_cen", 32'(sram_cen_n), 32'h1);
        check("mask_w2_wen", 32'(sram_wen_n), 32'hF0);
        @(negedge clk);
        drive(2'b01, 2'b00, 10'h205, 10'h000, 8'h00, 8'h00, 8'h00, 8'h00);
        #1 check("mask_rd_cen", 32'(sram_cen_n), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("mask_rsp_valid", 32'(rsp_valid), 32'h1);
        check("mask_rsp_rdata", 32'(rsp_rdata), 32'hF0);
        @(negedge clk);

        // One-cycle reset at INIT address 200.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_init(200, edges, seen);
        check("abort_init_at200", 32'(sram_a), 32'd200);
        rst_n = 1'b0;
        #1;
        check("abort_init_cen", 32'(sram_cen_n), 32'h3);
        check("abort_init_done", 32'(init_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init(-1, edges, seen);
        check("reinit_edges", 32'(edges), 32'd513);

        // Read granted, then reset lands on the next read-grant cycle.
        drive(2'b01, 2'b00, 10'h205, 10'h000, 8'h00, 8'h00, 8'h00, 8'h00);
        #1 check("rd_abort_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rd_abort_ready", 32'(req_ready), 32'h0);
        check("rd_abort_cen", 32'(sram_cen_n), 32'h3);
        check("rd_abort_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        run_init(-1, edges, seen);
        check("rd_abort_no_rsp", 32'(seen), 32'h0);
        check("rd_abort_reinit", 32'(edges), 32'd513);
        check("rd_abort_zero", 32'(nonzero_words()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
